// File: rtl/imm_gen_sequencer_if.sv
// Purpose: fetch-side and execute-side handshake bundle of the immediate generator.
// Latency: none (wires only).
// Backpressure: InstValid/InstReady upstream, ImmValid/ImmReady downstream.
interface imm_gen_sequencer_if;
    logic [31:0] Instruction;
    logic        InstValid;
    logic        InstReady;
    logic [63:0] BusImm;
    logic [2:0]  ExtCtrl;
    logic        ImmValid;
    logic        ImmReady;
    logic        DecodeErr;

    // Producer of instructions / consumer of immediates (fetch + execute side)
    modport master (
        output Instruction,
        output InstValid,
        output ImmReady,
        input  InstReady,
        input  BusImm,
        input  ExtCtrl,
        input  ImmValid,
        input  DecodeErr
    );

    // The immediate generation stage itself
    modport slave (
        input  Instruction,
        input  InstValid,
        input  ImmReady,
        output InstReady,
        output BusImm,
        output ExtCtrl,
        output ImmValid,
        output DecodeErr
    );
endinterface

// File: rtl/imm_gen_sequencer.sv
// Purpose: classify instructions and build 64-bit extended immediates; MOVZ shift sequence under IMMSEQ_MOVZ_EN.
// Latency: 1 cycle accept-to-ImmValid; MOVZ with hw=k adds k shift cycles.
// Backpressure: output held while ImmReady=0; InstReady only in IDLE or OUT-with-ImmReady (no InstValid path).
module imm_gen_sequencer (
    input  logic                 CLK,
    input  logic                 resetl,
    imm_gen_sequencer_if.slave   bus
);

    // ExtCtrl encodings
    localparam logic [2:0] EXT_ALU  = 3'b000;
    localparam logic [2:0] EXT_MEM  = 3'b001;
    localparam logic [2:0] EXT_BR   = 3'b010;
    localparam logic [2:0] EXT_CBR  = 3'b011;
`ifdef IMMSEQ_MOVZ_EN
    localparam logic [2:0] EXT_MOVZ = 3'b100;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef IMMSEQ_MOVZ_EN
        ST_SHIFT = 2'd2,
`endif
        ST_OUT   = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] bus_imm_q, bus_imm_d;
    logic [2:0]  ext_ctrl_q, ext_ctrl_d;
    logic        imm_vld_q, imm_vld_d;
    logic        dec_err_q, dec_err_d;
`ifdef IMMSEQ_MOVZ_EN
    logic [1:0]  cnt_q, cnt_d;
`endif

    // Classification results for the instruction currently on the bus
    logic        cls_known;
    logic [63:0] cls_imm;
    logic [2:0]  cls_ext;
`ifdef IMMSEQ_MOVZ_EN
    logic [1:0]  cls_hw;
`endif

    logic        inst_rdy;
    logic        accept;
    logic        emit;
    logic        load_new;

    // Ready depends only on state and downstream ready, never on InstValid
    assign inst_rdy = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.ImmReady);
    assign accept   = bus.InstValid && inst_rdy;
    assign emit     = imm_vld_q && bus.ImmReady;

    // First-match opcode classification and immediate extraction
    always_comb begin
        cls_known = 1'b0;
        cls_imm   = 64'd0;
        cls_ext   = EXT_ALU;
`ifdef IMMSEQ_MOVZ_EN
        cls_hw    = 2'd0;
`endif
        if (bus.Instruction[31:26] == 6'b000101) begin
            cls_known = 1'b1;
            cls_ext   = EXT_BR;
            cls_imm   = {{38{bus.Instruction[25]}}, bus.Instruction[25:0]};
        end else if (bus.Instruction[31:25] == 7'b1011010) begin
            cls_known = 1'b1;
            cls_ext   = EXT_CBR;
            cls_imm   = {{45{bus.Instruction[23]}}, bus.Instruction[23:5]};
        end else if ((bus.Instruction[31:21] == 11'b11111000010) ||
                     (bus.Instruction[31:21] == 11'b11111000000)) begin
            cls_known = 1'b1;
            cls_ext   = EXT_MEM;
            cls_imm   = {{55{bus.Instruction[20]}}, bus.Instruction[20:12]};
        end else if ((bus.Instruction[31:22] == 10'b1001000100) ||
                     (bus.Instruction[31:22] == 10'b1101000100)) begin
            cls_known = 1'b1;
            cls_ext   = EXT_ALU;
            cls_imm   = {52'd0, bus.Instruction[21:10]};
`ifdef IMMSEQ_MOVZ_EN
        end else if (bus.Instruction[31:23] == 9'b110100101) begin
            // Load the raw imm16; the SHIFT state positions it by hw
            cls_known = 1'b1;
            cls_ext   = EXT_MOVZ;
            cls_imm   = {48'd0, bus.Instruction[20:5]};
            cls_hw    = bus.Instruction[22:21];
`endif
        end
    end

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d    = state_q;
        bus_imm_d  = bus_imm_q;
        ext_ctrl_d = ext_ctrl_q;
        imm_vld_d  = imm_vld_q;
        dec_err_d  = 1'b0;
`ifdef IMMSEQ_MOVZ_EN
        cnt_d      = cnt_q;
`endif
        load_new   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_new = accept;
            end
`ifdef IMMSEQ_MOVZ_EN
            ST_SHIFT: begin
                bus_imm_d = {bus_imm_q[47:0], 16'h0000};
                cnt_d     = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d   = ST_OUT;
                    imm_vld_d = 1'b1;
                end
            end
`endif
            ST_OUT: begin
                // Without emit everything holds, so the bus is stable under backpressure
                if (emit) begin
                    if (accept) begin
                        load_new = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        imm_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                imm_vld_d = 1'b0;
            end
        endcase

        // Accepted instruction handling, shared by IDLE and back-to-back OUT
        if (load_new) begin
            if (!cls_known) begin
                dec_err_d = 1'b1;
                state_d   = ST_IDLE;
                imm_vld_d = 1'b0;
            end else begin
                bus_imm_d  = cls_imm;
                ext_ctrl_d = cls_ext;
`ifdef IMMSEQ_MOVZ_EN
                if (cls_hw != 2'd0) begin
                    state_d   = ST_SHIFT;
                    imm_vld_d = 1'b0;
                    cnt_d     = cls_hw;
                end else begin
`else
                begin
`endif
                    state_d   = ST_OUT;
                    imm_vld_d = 1'b1;
                end
            end
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q    <= ST_IDLE;
            bus_imm_q  <= 64'd0;
            ext_ctrl_q <= 3'b000;
            imm_vld_q  <= 1'b0;
            dec_err_q  <= 1'b0;
`ifdef IMMSEQ_MOVZ_EN
            cnt_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            bus_imm_q  <= bus_imm_d;
            ext_ctrl_q <= ext_ctrl_d;
            imm_vld_q  <= imm_vld_d;
            dec_err_q  <= dec_err_d;
`ifdef IMMSEQ_MOVZ_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign bus.InstReady = inst_rdy;
    assign bus.BusImm    = bus_imm_q;
    assign bus.ExtCtrl   = ext_ctrl_q;
    assign bus.ImmValid  = imm_vld_q;
    assign bus.DecodeErr = dec_err_q;

endmodule
